// File: rtl/sodor5_dmem_pkg.sv
// Shared types for the sodor5 data-memory arbiter.
// Request bundle, arbiter states and port indices.
package sodor5_dmem_pkg;

    localparam int NUM_WORDS  = 16;
    localparam int AW         = $clog2(NUM_WORDS);
    localparam int PORT_CORE  = 0;
    localparam int PORT_BDOOR = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } dmem_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_e;

endpackage

// File: rtl/sodor5_rr_pick2.sv
// Two-way round-robin picker.
// On a tie the port that did not win last time is granted.
module sodor5_rr_pick2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        unique case (valid_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/sodor5_dmem_arbiter.sv
// Shares one single-ported data memory between the core and the backdoor.
// One transaction in flight: IDLE accepts, ISSUE drives memory, RESP pulses.
module sodor5_dmem_arbiter
    import sodor5_dmem_pkg::*;
#(
    parameter int NUM_WORDS = 16,
    parameter int AW        = $clog2(NUM_WORDS)
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic [1:0]      req_valid_i,
    output logic [1:0]      req_ready_o,
    input  logic [1:0][31:0] req_addr_i,
    input  logic [1:0]      req_wr_i,
    input  logic [1:0][31:0] req_wdata_i,
    input  logic [1:0][3:0] req_wmask_i,
    output logic [1:0]      resp_valid_o,
    output logic [31:0]     resp_data_o,
    output logic            resp_err_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    output logic [3:0]      mem_wmask_o,
    input  logic [31:0]     mem_rdata_i
);

    arb_state_e  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;

    logic [1:0]  gnt;
    logic        sel;
    logic        in_rng;
    dmem_req_t   sel_req;

    sodor5_rr_pick2 u_pick (
        .valid_i      (req_valid_i),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    assign sel           = gnt[PORT_BDOOR];
    assign sel_req.addr  = req_addr_i[sel];
    assign sel_req.wr    = req_wr_i[sel];
    assign sel_req.wdata = req_wdata_i[sel];
    assign sel_req.wmask = req_wmask_i[sel];
    assign in_rng        = sel_req.addr[31:2] < 30'(NUM_WORDS);

    // Memory-side fields are registered at accept so they are stable in ISSUE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        err_d        = err_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        req_ready_o  = 2'b00;
        resp_valid_o = 2'b00;
        resp_data_o  = 32'h0;
        resp_err_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = gnt;
                if (|req_valid_i) begin
                    last_grant_d = sel;
                    owner_d      = sel;
                    wr_d         = sel_req.wr;
                    err_d        = !in_rng;
                    mem_en_d     = in_rng;
                    mem_we_d     = in_rng && sel_req.wr;
                    mem_addr_d   = sel_req.addr[AW+1:2];
                    mem_wdata_d  = sel_req.wdata;
                    mem_wmask_d  = sel_req.wmask;
                    state_d      = ISSUE;
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                resp_valid_o[owner_q] = 1'b1;
                resp_err_o            = err_q;
                if (!err_q && !wr_q) resp_data_o = mem_rdata_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_wmask_q  <= 4'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            err_q        <= err_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;

endmodule

// File: tb/tb_sodor5_dmem_arbiter.sv
// Directed bench for sodor5_dmem_arbiter with a behavioural memory.
// Memory is preloaded with mem[i] = i * 32'h11111111.
module tb_sodor5_dmem_arbiter;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_addr;
    logic [1:0]       req_wr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][3:0]  req_wmask;
    logic [1:0]       resp_valid;
    logic [31:0]      resp_data;
    logic             resp_err;
    logic             mem_en;
    logic             mem_we;
    logic [3:0]       mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wmask;
    logic [31:0]      mem_rdata;

    logic [31:0] mem [16];
    int checks = 0;
    int failures = 0;
    logic started = 1'b0;
    logic prev_en = 1'b0;

    always #5 clk = ~clk;

    sodor5_dmem_arbiter dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_wr_i     (req_wr),
        .req_wdata_i  (req_wdata),
        .req_wmask_i  (req_wmask),
        .resp_valid_o (resp_valid),
        .resp_data_o  (resp_data),
        .resp_err_o   (resp_err),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_wmask_o  (mem_wmask),
        .mem_rdata_i  (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("resp_overlap", 32'(&resp_valid), 32'h0);
            check("mem_en_b2b", 32'(mem_en && prev_en), 32'h0);
            prev_en = mem_en;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 2'b00;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic xact(input int p, input logic [31:0] a, input logic wr,
                        input logic [31:0] wd, input logic [3:0] wm,
                        input logic [31:0] a_after, input logic exp_en,
                        input logic [3:0] exp_idx, input logic [31:0] exp_data,
                        input logic exp_err);
        logic [1:0] onehot;
        onehot       = (p == 0) ? 2'b01 : 2'b10;
        req_valid[p] = 1'b1;
        req_addr[p]  = a;
        req_wr[p]    = wr;
        req_wdata[p] = wd;
        req_wmask[p] = wm;
        @(negedge clk);
        check("t0_ready", 32'(req_ready), 32'(onehot));
        step();
        req_valid[p] = 1'b0;
        req_addr[p]  = a_after;
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'h0);
        check("t1_mem_en", 32'(mem_en), 32'(exp_en));
        check("t1_mem_we", 32'(mem_we), 32'(exp_en && wr));
        if (exp_en) begin
            check("t1_mem_addr", 32'(mem_addr), 32'(exp_idx));
            check("t1_mem_wmask", 32'(mem_wmask), 32'(wm));
            check("t1_mem_wdata", mem_wdata, wd);
        end
        step();
        @(negedge clk);
        check("t2_resp_valid", 32'(resp_valid), 32'(onehot));
        check("t2_resp_data", resp_data, exp_data);
        check("t2_resp_err", 32'(resp_err), 32'(exp_err));
        step();
        @(negedge clk);
        check("t3_resp_idle", 32'(resp_valid), 32'h0);
        step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = i * 32'h11111111;
        mem_rdata = 32'h0;
        req_addr  = '0;
        req_wr    = '0;
        req_wdata = '0;
        req_wmask = '0;
        do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wmask", 32'(mem_wmask), 32'h0);
        step();
        reset_n = 1'b1;
        started = 1'b1;

        // 1: single core load
        xact(0, 32'h8, 1'b0, 32'h0, 4'h0, 32'h8, 1'b1, 4'd2, 32'h22222222, 1'b0);

        // 2: both ports valid every cycle from a fresh reset
        do_reset();
        req_valid = 2'b11;
        req_addr  = {32'hC, 32'h4};
        req_wr    = 2'b00;
        for (int k = 0; k < 12; k++) begin
            int ph;
            int port;
            ph   = k % 3;
            port = (k / 3) % 2;
            @(negedge clk);
            if (ph == 0) begin
                check("rr_ready", 32'(req_ready), (port == 1) ? 32'h2 : 32'h1);
            end else if (ph == 1) begin
                check("rr_mem_addr", 32'(mem_addr), (port == 1) ? 32'h3 : 32'h1);
                check("rr_ready_busy", 32'(req_ready), 32'h0);
            end else begin
                check("rr_resp_valid", 32'(resp_valid), (port == 1) ? 32'h2 : 32'h1);
                check("rr_resp_data", resp_data,
                      (port == 1) ? 32'h33333333 : 32'h11111111);
            end
            step();
        end
        req_valid = 2'b00;
        step();

        // 3: backdoor partial store, then core readback
        xact(1, 32'h14, 1'b1, 32'hDEADBEEF, 4'b0011, 32'h14, 1'b1, 4'd5, 32'h0, 1'b0);
        xact(0, 32'h14, 1'b0, 32'h0, 4'h0, 32'h14, 1'b1, 4'd5, 32'h5555BEEF, 1'b0);

        // 4: out-of-range load
        xact(0, 32'h40, 1'b0, 32'h0, 4'h0, 32'h40, 1'b0, 4'd0, 32'h0, 1'b1);

        // 6: address changes after accept
        xact(0, 32'h8, 1'b0, 32'h0, 4'h0, 32'h30, 1'b1, 4'd2, 32'h22222222, 1'b0);

        // 5: reset during ISSUE, then tie goes to core
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'hC;
        @(negedge clk);
        check("r5_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        reset_n   = 1'b0;
        @(negedge clk);
        check("r5_issue_en", 32'(mem_en), 32'h1);
        step();
        @(negedge clk);
        check("r5_no_resp", 32'(resp_valid), 32'h0);
        check("r5_mem_en_clr", 32'(mem_en), 32'h0);
        step();
        reset_n   = 1'b1;
        req_valid = 2'b11;
        req_addr  = {32'hC, 32'h4};
        @(negedge clk);
        check("r5_tie_core", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        check("r5_mem_addr", 32'(mem_addr), 32'h1);
        step();
        @(negedge clk);
        check("r5_resp_valid", 32'(resp_valid), 32'h1);
        check("r5_resp_data", resp_data, 32'h11111111);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
